time_entry_loader: RTL

Keypad-side loader for the countdown timer chain. It collects BCD digits from the keypad encoder into an m:ss entry buffer and, on start, drives the `data` buses and active-low `loadn` of the minute-ones counter and the mod-6 and mod-10 seconds counters. It then enables the chain and waits for the chain's `zero` flag. It is the producer end of the counters' load/enable interface.

---
 rtl/timer_pkg.sv | 24 ++
 rtl/bcd_shift_buffer.sv | 54 +++++
 rtl/time_entry_loader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and limits for the keypad time-entry loader.
// Holds the loader FSM state encoding, the BCD digit type and entry limits.
// Pure declarations: no logic, no latency, no flow control.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_LOAD  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int MAX_DIGITS   = 3;
    localparam int BCD_MAX      = 9;
    localparam int SEC_TENS_MAX = 5;

    // A keypad code is a usable digit only when it is 0..9.
    function automatic logic is_bcd(input bcd_t d);
        return d <= 4'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_shift_buffer.sv
// Three-digit m:ss BCD entry buffer with digit count and full flag.
// Latency: shift/clear/normalize take effect on the sampling edge (1 cycle).
// No backpressure: the caller gates shift with the full flag.
// Ports: clock/clearn; shift+key push a digit in from the right; clear empties
// the buffer; normalize folds sec_tens>5 into the minute digit (saturating at
// 9:59); min_ones/sec_tens/sec_ones, entry_count and full are registered.
module bcd_shift_buffer
    import timer_pkg::*;
(
    input  logic       clock,
    input  logic       clearn,
    input  logic       shift,
    input  logic       clear,
    input  logic       normalize,
    input  logic [3:0] key,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [1:0] entry_count,
    output logic       full
);

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            min_ones    <= '0;
            sec_tens    <= '0;
            sec_ones    <= '0;
            entry_count <= '0;
        end else if (clear) begin
            min_ones    <= '0;
            sec_tens    <= '0;
            sec_ones    <= '0;
            entry_count <= '0;
        end else if (normalize) begin
            // 60+ seconds roll one minute over; with no minute headroom
            // left the entry pins to the largest representable time.
            if (min_ones == 4'(BCD_MAX)) begin
                sec_tens <= 4'(SEC_TENS_MAX);
                sec_ones <= 4'(BCD_MAX);
            end else begin
                min_ones <= min_ones + 4'd1;
                sec_tens <= sec_tens - 4'd6;
            end
        end else if (shift) begin
            min_ones    <= sec_tens;
            sec_tens    <= sec_ones;
            sec_ones    <= key;
            entry_count <= entry_count + 2'd1;
        end
    end

    assign full = (entry_count == 2'(MAX_DIGITS));

endmodule

// File: rtl/time_entry_loader.sv
// Keypad loader for the m:ss countdown chain: collect digits, pulse loadn, run until zero.
// Latency: key->buffer 1 cycle; start->loadn low on the sampling edge (+1 with ENTRY_NORMALIZE_EN).
// No backpressure: keys arriving while full, loading or running are dropped.
// Ports: clock, clearn (async active-low); key/key_valid, start, cancel from the
// keypad; zero from the chain; min_ones/sec_tens/sec_ones/loadn/en to the chain;
// entry_count and err status. All outputs are registered.
// Build option ENTRY_NORMALIZE_EN: seconds-tens above 5 are folded into minutes
// instead of rejecting the start with an err pulse.
module time_entry_loader
    import timer_pkg::*;
#(
    parameter int LOADN_CYCLES = 1
) (
    input  logic       clock,
    input  logic       clearn,
    input  logic [3:0] key,
    input  logic       key_valid,
    input  logic       start,
    input  logic       cancel,
    input  logic       zero,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       loadn,
    output logic       en,
    output logic [1:0] entry_count,
    output logic       err
);

    state_t     state, state_nxt;
    logic [1:0] load_cnt;
    logic       load_done;
    logic       run_first;
    logic       pend_start, pend_start_nxt;
    logic       full;
    logic       shift, clear, normalize, reject;
    logic       tens_bad;

    assign load_done = (load_cnt == 2'(LOADN_CYCLES - 1));
    assign tens_bad  = (sec_tens > 4'(SEC_TENS_MAX));

    bcd_shift_buffer u_buf (
        .clock       (clock),
        .clearn      (clearn),
        .shift       (shift),
        .clear       (clear),
        .normalize   (normalize),
        .key         (key),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .entry_count (entry_count),
        .full        (full)
    );

    // State register plus the registered chain-facing strobes, which are
    // decoded from the next state so they change on the same edge as state.
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            state      <= ST_IDLE;
            load_cnt   <= '0;
            run_first  <= 1'b1;
            pend_start <= 1'b0;
            loadn      <= 1'b1;
            en         <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            load_cnt   <= (state == ST_LOAD && state_nxt == ST_LOAD) ? load_cnt + 2'd1 : 2'd0;
            // High only in the first RUN cycle, while the counters settle.
            run_first  <= (state != ST_RUN);
            pend_start <= pend_start_nxt;
            loadn      <= (state_nxt != ST_LOAD);
            en         <= (state_nxt == ST_RUN);
            err        <= reject;
        end
    end

    // Next-state logic; cancel beats start, start beats key.
    always_comb begin
        state_nxt      = state;
        pend_start_nxt = 1'b0;
        if (cancel) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (shift) state_nxt = ST_ENTRY;
                end
                ST_ENTRY: begin
                    if (pend_start) begin
                        state_nxt = ST_LOAD;
                    end else if (start) begin
                        if (!tens_bad) begin
                            state_nxt = ST_LOAD;
                        end else begin
`ifdef ENTRY_NORMALIZE_EN
                            // Spend one cycle rewriting the buffer first.
                            pend_start_nxt = 1'b1;
`endif
                        end
                    end
                end
                ST_LOAD: begin
                    if (load_done) state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (zero && !run_first) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Buffer controls and the start-reject strobe.
    always_comb begin
        shift     = 1'b0;
        clear     = 1'b0;
        normalize = 1'b0;
        reject    = 1'b0;
        if (cancel) begin
            clear = 1'b1;
        end else begin
            case (state)
                ST_IDLE, ST_ENTRY: begin
                    shift = key_valid && is_bcd(key) && !full && !start && !pend_start;
                    if (state == ST_ENTRY && start && !pend_start && tens_bad) begin
`ifdef ENTRY_NORMALIZE_EN
                        normalize = 1'b1;
`else
                        reject    = 1'b1;
`endif
                    end
                end
                ST_RUN: begin
                    clear = zero && !run_first;
                end
                default: ;
            endcase
        end
    end

endmodule
